// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-flight destination tracking, operand forwarding select and load-use stall.
// Optional stall counter output o_stall_cnt is built when HAZARD_PERF_EN is defined.
module hazard_scoreboard #(
  parameter int STAGES = 3,
  parameter int AW = 5,
  parameter int LOAD_READY = 2,
  localparam int FW = $clog2(STAGES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_dec_valid,
  input  logic [AW-1:0] i_dec_ra1,
  input  logic [AW-1:0] i_dec_ra2,
  input  logic          i_dec_use1,
  input  logic          i_dec_use2,
  input  logic          i_dec_we,
  input  logic [AW-1:0] i_dec_wa,
  input  logic          i_dec_load,
  input  logic          i_flush,
  output logic          o_stall,
  output logic          o_issue,
  output logic [FW-1:0] o_fwd1,
  output logic [FW-1:0] o_fwd2
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]   o_stall_cnt
`endif
);
  logic [STAGES:1] valid_q, valid_d, load_q, load_d;
  logic [AW-1:0]   wa_q [1:STAGES];
  logic [AW-1:0]   wa_d [1:STAGES];
  logic [FW-1:0]   sel1, sel2;
  logic            rdy1, rdy2, ins;
  // Scan oldest to youngest so the youngest matching stage is the last one kept.
  always_comb begin
    sel1 = '0;
    sel2 = '0;
    rdy1 = 1'b1;
    rdy2 = 1'b1;
    for (int k = STAGES; k >= 1; k--) begin
      if (i_dec_use1 && i_dec_ra1 != '0 && valid_q[k] && wa_q[k] == i_dec_ra1) begin
        sel1 = FW'(k);
        rdy1 = !load_q[k] || k >= LOAD_READY;
      end
      if (i_dec_use2 && i_dec_ra2 != '0 && valid_q[k] && wa_q[k] == i_dec_ra2) begin
        sel2 = FW'(k);
        rdy2 = !load_q[k] || k >= LOAD_READY;
      end
    end
    o_stall = i_dec_valid && !i_flush && (!rdy1 || !rdy2);
    o_issue = i_dec_valid && !o_stall && !i_flush;
    o_fwd1  = rdy1 ? sel1 : '0;
    o_fwd2  = rdy2 ? sel2 : '0;
    ins     = o_issue && i_dec_we && i_dec_wa != '0;
    valid_d = {valid_q[STAGES-1:1], ins};
    load_d  = {load_q[STAGES-1:1], ins && i_dec_load};
    wa_d[1] = ins ? i_dec_wa : '0;
    for (int k = 2; k <= STAGES; k++) wa_d[k] = wa_q[k-1];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      load_q  <= '0;
      wa_q    <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      load_q  <= load_d;
      wa_q    <= wa_d;
    end
  end
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  always_comb stall_cnt_d = (o_stall && stall_cnt_q != '1) ? stall_cnt_q + 32'd1 : stall_cnt_q;
  always_ff @(posedge clk) stall_cnt_q <= rst ? '0 : stall_cnt_d;
  assign o_stall_cnt = stall_cnt_q;
`endif
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter STAGES, default 3, SHALL set the in-flight stages after decode (1=EXE ... STAGES=WRT); range 2..8.
REQ-002 Parameter AW, default 5, SHALL set the register address width.
REQ-003 Parameter LOAD_READY, default 2, SHALL set the first stage index whose load result is forwardable; range 1..STAGES.
REQ-004 FW = $clog2(STAGES+1).
REQ-005 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-006 rst  in  1  reset; synchronous, active-high.
REQ-007 i_dec_valid  in  1  decode holds an instruction.
REQ-008 i_dec_ra1, i_dec_ra2  in  AW  source register addresses.
REQ-009 i_dec_use1, i_dec_use2  in  1  source actually read.
REQ-010 i_dec_we  in  1  instruction writes a register.
REQ-011 i_dec_wa  in  AW  destination address.
REQ-012 i_dec_load  in  1  result comes from data memory.
REQ-013 i_flush  in  1  taken branch/jump; kills the decode instruction.
REQ-014 o_stall  out  1  hold fetch/decode, inject bubble.
REQ-015 o_issue  out  1  decode instruction advances into stage 1 this cycle.
REQ-016 o_fwd1, o_fwd2  out  FW  operand source: 0 = register file, k = stage-k result.

Function
REQ-017 State SHALL be STAGES entries {valid, wa[AW], load}; entry k is the instruction currently in stage k.
REQ-018 Every cycle, entry k SHALL move to k+1; entry STAGES SHALL retire (write-through register file, no forwarding needed).
REQ-019 Entry 1 SHALL load {1, i_dec_wa, i_dec_load} when o_issue && i_dec_we && i_dec_wa != 0; otherwise a bubble (valid=0).
REQ-020 Per source s: match = use_s && ra_s != 0 && valid_k && wa_k == ra_s; the smallest matching k (youngest) SHALL be selected.
REQ-021 Selected entry is ready iff !load_k || k >= LOAD_READY.
REQ-022 o_fwd_s SHALL equal the selected k when ready, else 0; 0 when no match.
REQ-023 o_stall SHALL be 1 iff i_dec_valid && !i_flush && some used source selects a not-ready entry.
REQ-024 o_issue = i_dec_valid && !o_stall && !i_flush.
REQ-025 During stall the pipeline SHALL keep advancing; the stall clears once the producing load reaches LOAD_READY (1 stall cycle for defaults).
REQ-026 i_flush SHALL override stall: o_stall=0, no insert; in-flight entries unaffected.
REQ-027 o_stall, o_issue, o_fwd* SHALL be combinational from state and current inputs; no latency beyond one register stage of state.
REQ-028 Register 0 SHALL never be tracked or forwarded.

Reset
REQ-029 rst=1 SHALL clear every entry's valid, wa and load on the next rising edge; reset dominates issue and flush.
REQ-030 After reset: o_stall=0, o_fwd1=o_fwd2=0, o_issue follows i_dec_valid && !i_flush.
REQ-031 Reset mid-stall SHALL drop the pending hazard; no stall in the cycle after reset.

Configuration
REQ-032 Macro HAZARD_PERF_EN defined: SHALL add output o_stall_cnt  out  32, incremented each cycle o_stall=1, saturating at 32'hFFFF_FFFF, cleared by rst.
REQ-033 Macro HAZARD_PERF_EN undefined: port and counter SHALL be absent; all other behaviour identical.

Verification (STAGES=3, LOAD_READY=2)
REQ-034 ALU write $5 issued cycle 0; cycle 1 decode ra1=5 use1=1 -> o_fwd1=1, o_stall=0; cycle 2 same read -> o_fwd1=2.
REQ-035 Load to $8 issued cycle 0; cycle 1 ra2=8 -> o_stall=1, o_issue=0; cycle 2 -> o_stall=0, o_fwd2=2, o_issue=1.
REQ-036 Write to $0 then read ra1=0 -> o_fwd1=0, o_stall=0.
REQ-037 ALU writes to $3 issued on consecutive cycles; next cycle ra1=3 -> o_fwd1=1 (youngest wins).
REQ-038 Load-use condition with i_flush=1 -> o_stall=0, o_issue=0; following cycle entry 1 valid=0.
REQ-039 rst=1 during load-use stall -> next cycle o_stall=0, o_fwd1=o_fwd2=0; with HAZARD_PERF_EN, o_stall_cnt=0.
